// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with parity and framing checks.
// Each completed frame is presented with a one-cycle valid pulse.
module uart_rx #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int BIT_LENGHT  = 8,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iRx,
    output logic [BIT_LENGHT-1:0] oData_rx,
    output logic                  oValid_rx,
    output logic                  oParity_err,
    output logic                  oFrame_err,
    output logic                  oBusy_rx
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;

    if (DIV < 1 || BIT_LENGHT < 5 || BIT_LENGHT > 8 || PARITY_TYPE < 0 || PARITY_TYPE > 2 || STOP_BITS < 1) begin : gBadParam
        $error("uart_rx: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} stateT;

    stateT                 state, nextState;
    logic                  rxMeta, rxS;
    logic [PW-1:0]         presc;
    logic [3:0]            tickCnt;
    logic [2:0]            bitIdx;
    logic [BIT_LENGHT-1:0] shiftReg;
    logic                  parityErr, osTick, midBit, lastBit, tickClr;

    assign osTick  = presc == PW'(DIV - 1);
    assign midBit  = osTick && tickCnt == 4'd15;
    assign lastBit = bitIdx == 3'(BIT_LENGHT - 1);

    always_comb begin
        nextState = state;
        tickClr   = 1'b0;
        case (state)
            IDLE:      if (osTick && !rxS) begin nextState = START; tickClr = 1'b1; end
            START:     if (osTick && tickCnt == 4'd7) begin nextState = rxS ? IDLE : DATA; tickClr = 1'b1; end
            DATA:      if (midBit && lastBit) begin nextState = PARITY_TYPE != 0 ? PARITY : STOP; tickClr = 1'b1; end
            PARITY:    if (midBit) begin nextState = STOP; tickClr = 1'b1; end
            STOP:      if (midBit) begin nextState = rxS ? IDLE : WAIT_IDLE; tickClr = 1'b1; end
            WAIT_IDLE: if (rxS) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            rxMeta      <= 1'b1;
            rxS         <= 1'b1;
            presc       <= '0;
            tickCnt     <= '0;
            bitIdx      <= '0;
            shiftReg    <= '0;
            parityErr   <= 1'b0;
            oData_rx    <= '0;
            oValid_rx   <= 1'b0;
            oParity_err <= 1'b0;
            oFrame_err  <= 1'b0;
            oBusy_rx    <= 1'b0;
        end else begin
            rxMeta      <= iRx;
            rxS         <= rxMeta;
            presc       <= osTick ? '0 : presc + 1'b1;
            tickCnt     <= tickClr ? 4'd0 : osTick ? tickCnt + 4'd1 : tickCnt;
            oValid_rx   <= 1'b0;
            oParity_err <= 1'b0;
            oFrame_err  <= 1'b0;
            oBusy_rx    <= nextState != IDLE;
            if (state == START) begin
                bitIdx    <= '0;
                parityErr <= 1'b0;
            end
            if (state == DATA && midBit) begin
                shiftReg[bitIdx] <= rxS;
                bitIdx           <= bitIdx + 3'd1;
            end
            // odd parity expects an odd count of ones across data and parity bit
            if (state == PARITY && midBit)
                parityErr <= PARITY_TYPE == 1 ? ~(^shiftReg ^ rxS) : (^shiftReg ^ rxS);
            if (state == STOP && midBit) begin
                oData_rx    <= shiftReg;
                oValid_rx   <= 1'b1;
                oParity_err <= parityErr;
                oFrame_err  <= ~rxS;
            end
        end
    end
endmodule
